// File: rtl/counter_ctrl_if.sv
// Board-side signal bundle for counter_ctrl: raw push-buttons in, counter controls out.
// master = board/test side driving buttons, slave = the controller.
interface counter_ctrl_if;
    logic       btn_run_stop;
    logic       btn_clear;
    logic       btn_mode;
    logic       en;
    logic       clear;
    logic       mode;
    logic [2:0] state_led;

    modport master (
        output btn_run_stop, btn_clear, btn_mode,
        input  en, clear, mode, state_led
    );

    modport slave (
        input  btn_run_stop, btn_clear, btn_mode,
        output en, clear, mode, state_led
    );
endinterface

// File: rtl/counter_ctrl.sv
// Run/stop/clear/mode controller: synchronizes and debounces three buttons,
// turns presses into single-cycle events and sequences STOP/RUN/CLEAR.
module counter_ctrl #(
    parameter int unsigned DB_CYCLES = 100_000
) (
    input  logic            clk,
    input  logic            reset,
    counter_ctrl_if.slave   bus
);
    localparam int unsigned    CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);

    // One-hot encoding lets the state register drive state_led directly.
    typedef enum logic [2:0] {
        ST_STOP  = 3'b001,
        ST_RUN   = 3'b010,
        ST_CLEAR = 3'b100
    } state_t;

    state_t        state, state_next;
    logic          mode_q;

    // Bit order for all button vectors: [0] run_stop, [1] clear, [2] mode.
    logic [2:0]    raw, meta, sync, db_level, db_level_d;
    logic [CW-1:0] db_cnt [3];
    logic          p_run_stop, p_clear, p_mode;

    assign raw = {bus.btn_mode, bus.btn_clear, bus.btn_run_stop};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta       <= '0;
            sync       <= '0;
            db_level   <= '0;
            db_level_d <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            meta       <= raw;
            sync       <= meta;
            db_level_d <= db_level;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_level[i] <= sync[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Rising edge of the debounced level only; releases produce nothing.
    assign p_run_stop = db_level[0] & ~db_level_d[0];
    assign p_clear    = db_level[1] & ~db_level_d[1];
    assign p_mode     = db_level[2] & ~db_level_d[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_STOP;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_STOP: begin
                if (p_run_stop) begin
                    state_next = ST_RUN;
                end else if (p_clear) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (p_run_stop) begin
                    state_next = ST_STOP;
                end
            end
            ST_CLEAR: state_next = ST_STOP;
            default:  state_next = ST_STOP;
        endcase
    end

    // Direction only changes while stopped; clear leaves it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= 1'b0;
        end else if (state == ST_STOP && p_mode) begin
            mode_q <= ~mode_q;
        end
    end

    assign bus.en        = (state == ST_RUN);
    assign bus.clear     = (state == ST_CLEAR);
    assign bus.mode      = mode_q;
    assign bus.state_led = state;
endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with DB_CYCLES = 4 (press-to-output latency 7 clocks).
module tb_counter_ctrl;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   clear_cnt;

    counter_ctrl_if bus ();

    counter_ctrl #(.DB_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (bus.clear === 1'b1) clear_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then step 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: bus.btn_run_stop = v;
            1: bus.btn_clear    = v;
            default: bus.btn_mode = v;
        endcase
    endtask

    // Hold a button for cyc sampled edges, release, then wait out the debounced release.
    task automatic pulse_btn(input int b, input int cyc);
        set_btn(b, 1'b1);
        tick(cyc);
        set_btn(b, 1'b0);
        tick(12);
    endtask

    initial begin
        int c0;
        n_tests = 0;
        n_fail = 0;
        clear_cnt = 0;
        bus.btn_run_stop = 1'b0;
        bus.btn_clear = 1'b0;
        bus.btn_mode = 1'b0;
        reset = 1'b0;
        tick(3);
        check("rst_en", bus.en, 0);
        check("rst_clear", bus.clear, 0);
        check("rst_mode", bus.mode, 0);
        check("rst_led", bus.state_led, 3'b001);
        reset = 1'b1;
        tick(2);

        // Run latency: RUN appears on the 7th edge after the press.
        bus.btn_run_stop = 1'b1;
        tick(6);
        check("run_lat_early", bus.en, 0);
        tick(1);
        check("run_lat_en", bus.en, 1);
        check("run_lat_led", bus.state_led, 3'b010);
        tick(3);
        bus.btn_run_stop = 1'b0;
        tick(12);
        check("run_after_release", bus.en, 1);
        pulse_btn(0, 5);
        check("stop_en", bus.en, 0);
        check("stop_led", bus.state_led, 3'b001);

        // Glitches one cycle short of the debounce window.
        c0 = clear_cnt;
        pulse_btn(0, 3);
        check("glitch_run_en", bus.en, 0);
        check("glitch_run_led", bus.state_led, 3'b001);
        pulse_btn(1, 3);
        check("glitch_clr_cnt", clear_cnt - c0, 0);
        check("glitch_clr_led", bus.state_led, 3'b001);
        pulse_btn(0, 4);
        check("min_press_en", bus.en, 1);
        pulse_btn(0, 4);
        check("min_press_stop", bus.en, 0);

        // Clear from STOP: one-cycle pulse.
        c0 = clear_cnt;
        bus.btn_clear = 1'b1;
        tick(6);
        check("clr_early", bus.clear, 0);
        tick(1);
        check("clr_pulse", bus.clear, 1);
        check("clr_led", bus.state_led, 3'b100);
        check("clr_en", bus.en, 0);
        tick(1);
        check("clr_done", bus.clear, 0);
        check("clr_done_led", bus.state_led, 3'b001);
        bus.btn_clear = 1'b0;
        tick(12);
        check("clr_count", clear_cnt - c0, 1);

        // Clear ignored in RUN.
        pulse_btn(0, 4);
        c0 = clear_cnt;
        pulse_btn(1, 5);
        check("run_clr_cnt", clear_cnt - c0, 0);
        check("run_clr_en", bus.en, 1);

        // Mode ignored in RUN, toggles in STOP.
        pulse_btn(2, 5);
        check("run_mode_hold", bus.mode, 0);
        pulse_btn(0, 4);
        check("stop_again", bus.en, 0);
        pulse_btn(2, 5);
        check("mode_toggle1", bus.mode, 1);
        pulse_btn(2, 5);
        check("mode_toggle0", bus.mode, 0);

        // All three together in STOP: RUN wins, mode still toggles.
        c0 = clear_cnt;
        bus.btn_run_stop = 1'b1;
        bus.btn_clear = 1'b1;
        bus.btn_mode = 1'b1;
        tick(7);
        check("sim3_en", bus.en, 1);
        check("sim3_led", bus.state_led, 3'b010);
        check("sim3_mode", bus.mode, 1);
        bus.btn_run_stop = 1'b0;
        bus.btn_clear = 1'b0;
        bus.btn_mode = 1'b0;
        tick(12);
        check("sim3_no_clr", clear_cnt - c0, 0);
        pulse_btn(0, 4);
        check("sim3_stop_mode", bus.mode, 1);

        // Clear + mode together in STOP.
        c0 = clear_cnt;
        bus.btn_clear = 1'b1;
        bus.btn_mode = 1'b1;
        tick(7);
        check("sim2_clear", bus.clear, 1);
        check("sim2_mode", bus.mode, 0);
        tick(1);
        check("sim2_led", bus.state_led, 3'b001);
        bus.btn_clear = 1'b0;
        bus.btn_mode = 1'b0;
        tick(12);
        check("sim2_clr_cnt", clear_cnt - c0, 1);

        // Reset mid-RUN with mode=1, then release with run/stop held.
        pulse_btn(2, 4);
        pulse_btn(0, 4);
        check("pre_rst_en", bus.en, 1);
        check("pre_rst_mode", bus.mode, 1);
        bus.btn_run_stop = 1'b1;
        reset = 1'b0;
        #1;
        check("async_rst_en", bus.en, 0);
        check("async_rst_mode", bus.mode, 0);
        check("async_rst_clear", bus.clear, 0);
        check("async_rst_led", bus.state_led, 3'b001);
        tick(3);
        reset = 1'b1;
        tick(6);
        check("held_rst_early", bus.en, 0);
        tick(1);
        check("held_rst_en", bus.en, 1);
        tick(20);
        check("held_rst_once", bus.state_led, 3'b010);
        bus.btn_run_stop = 1'b0;
        tick(12);
        check("held_rst_final", bus.en, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Run/stop/clear/mode controller for the 10 Hz up/down 0–9999 counter datapath. It sits between the three raw board push-buttons and the counter's `en`, `clear` and `mode` inputs. The block does the following:
- synchronizes and debounces each button;
- converts each button press into a single-cycle event;
- sequences the counter through STOP, RUN and CLEAR with a Moore state machine.

## Interface
Parameters:
- `DB_CYCLES`, default 100_000 — consecutive stable cycles required before a debounced level changes (1 ms at 100 MHz); legal range ≥ 2.

Ports:
- `clk`  input  1  system clock; the only clock.
- `reset`  input  1  asynchronous, active-low reset.
- `btn_run_stop`  input  1  raw button, asynchronous to `clk`, active-high.
- `btn_clear`  input  1  raw button, asynchronous, active-high.
- `btn_mode`  input  1  raw button, asynchronous, active-high.
- `en`  output  1  counter/divider enable; 1 only in RUN.
- `clear`  output  1  synchronous clear to counter and divider; 1 only in CLEAR.
- `mode`  output  1  count direction: 0 = up, 1 = down.
- `state_led`  output  3  one-hot state indicator: [0] STOP, [1] RUN, [2] CLEAR.

## Operation
Button path (three identical, independent instances):
- 2-flop synchronizer produces `sync`.
- Debounce counter of width $clog2(DB_CYCLES):
  - Cleared to 0 whenever `sync` == `db_level`.
  - Otherwise increments.
  - On the edge where the counter equals DB_CYCLES-1 and `sync` still differs, `db_level` <= `sync` and the counter returns to 0.
- Any glitch shorter than DB_CYCLES cycles restarts the count and never changes `db_level`.
- Press event `p_*` = `db_level` & ~`db_level_d` (registered previous value). It is combinational and exactly 1 cycle wide per debounced press. Releases generate no event.

State machine (registered, Moore outputs):
- STOP:
  - `p_run_stop` -> RUN.
  - Else `p_clear` -> CLEAR.
  - Else stay.
  - `p_run_stop` has priority over `p_clear` in the same cycle.
- RUN:
  - `p_run_stop` -> STOP.
  - `p_clear` and `p_mode` are ignored (not queued).
- CLEAR: unconditionally -> STOP after exactly 1 cycle. All events in this cycle are ignored.
- Encoding is free. `state_led` must be one-hot and must match the state.

Mode register:
- Toggles on `p_mode` only while the state is STOP, including a cycle where STOP also takes `p_run_stop` or `p_clear`.
- Holds its value through RUN and CLEAR.
- Not affected by CLEAR: clear zeroes the count, not the direction.

Outputs:
- `en` = (state == RUN).
- `clear` = (state == CLEAR).
- `mode` = mode register.
- All outputs are driven directly from registers or from state decode, with no input-to-output combinational path.

Reset (`reset` low, asynchronous):
- State = STOP, `en` = 0, `clear` = 0, `mode` = 0, `state_led` = 3'b001.
- Synchronizers, `db_level`, `db_level_d` and debounce counters all go to 0.
- A button already held at reset release produces one press event after the normal debounce latency.
- Reset asserted mid-RUN or mid-CLEAR forces STOP immediately; there is no pending event afterwards.

## Timing
- Raw transition sampled at edge 0:
  - `sync` changes at edge 2.
  - `db_level` changes at edge 2+DB_CYCLES.
  - Press event is high during the following cycle.
  - State and outputs update at edge 3+DB_CYCLES.
  - Total press-to-output latency: DB_CYCLES+3 clocks.
- `clear` is high for exactly 1 clock per accepted clear press.
- A held button produces one event only. The next event requires a debounced release (≥ DB_CYCLES stable low) followed by a new press.
- The three buttons are fully independent, so simultaneous events resolve in the same cycle per the priorities above.

## Test plan
All scenarios run with DB_CYCLES = 4.
- Reset check: pulse `reset` low, then release -> `en`=0, `clear`=0, `mode`=0, `state_led`=001. Press `btn_run_stop` for 10 cycles -> `en`=1 and `state_led`=010 exactly 7 clocks after the press edge, and `en` stays 1 after release. Second press -> `en`=0.
- Debounce: 3-cycle glitch on `btn_run_stop`, and separately on `btn_clear` -> no change to any output. A 4-cycle stable press is accepted.
- Clear sequence: in STOP, press `btn_clear` -> `clear`=1 for exactly 1 cycle, `state_led`=100 during that cycle, then 001. Press `btn_clear` in RUN -> `clear` never asserts, and `en` stays 1.
- Mode: press `btn_mode` in STOP -> `mode`=1; second press -> `mode`=0. Press `btn_mode` in RUN -> `mode` is unchanged.
- Simultaneous:
  - `btn_run_stop`, `btn_clear` and `btn_mode` pressed on the same edge in STOP (`mode`=0) -> RUN, `clear` never asserts, `mode`=1.
  - `btn_clear` and `btn_mode` together in STOP -> one `clear` pulse and `mode` toggles.
- Reset mid-operation: assert `reset` while in RUN with `mode`=1 -> all outputs immediately at reset values. Releasing `reset` with `btn_run_stop` held -> RUN exactly once, 7 clocks after release.
